// File: rtl/id_stage_pipe.sv
// Instruction-decode stage: register file with WB bypass, immediate generation,
// early branch/jump resolution, and the ID/EX register with stall/flush control.
module id_stage_pipe #(
  parameter int              XLEN      = 32,
  parameter int              NREGS     = 32,
  parameter logic [XLEN-1:0] RESET_PC  = '0,
  parameter logic [31:0]     NOP_INSTR = 32'h0000_0013,
  parameter bit              BYPASS_WB = 1'b1,
  localparam int             AW        = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            id_valid,
  output logic            id_ready,
  input  logic [XLEN-1:0] id_pc,
  input  logic [31:0]     id_instr,
  input  logic [2:0]      imm_sel,
  input  logic            flush,
  input  logic            wb_we,
  input  logic [AW-1:0]   wb_rd_addr,
  input  logic [XLEN-1:0] wb_data,
  output logic            ex_valid,
  input  logic            ex_ready,
  output logic [XLEN-1:0] ex_pc,
  output logic [31:0]     ex_instr,
  output logic [XLEN-1:0] ex_rs1_data,
  output logic [XLEN-1:0] ex_rs2_data,
  output logic [XLEN-1:0] ex_imm,
  output logic [AW-1:0]   ex_rs1_addr,
  output logic [AW-1:0]   ex_rs2_addr,
  output logic [AW-1:0]   ex_rd_addr,
  output logic            br_taken,
  output logic [XLEN-1:0] br_target,
  output logic [XLEN-1:0] jal_target,
  output logic [XLEN-1:0] jalr_target,
  output logic            hazard_stall
);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     instr;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [XLEN-1:0] imm;
    logic [AW-1:0]   rs1_addr;
    logic [AW-1:0]   rs2_addr;
    logic [AW-1:0]   rd_addr;
  } idex_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  logic [AW-1:0]   rs1, rs2, rd;
  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [XLEN-1:0] rf [NREGS];
  logic [XLEN-1:0] rs1_val, rs2_val;

  assign rs1    = AW'(id_instr[19:15]);
  assign rs2    = AW'(id_instr[24:20]);
  assign rd     = AW'(id_instr[11:7]);
  assign opcode = id_instr[6:0];
  assign funct3 = id_instr[14:12];

  // x0 is hardwired; every other entry is an independent register
  assign rf[0] = '0;
  for (genvar g = 1; g < NREGS; g++) begin : g_rf
    always_ff @(posedge clk or posedge rst) begin
      if (rst)                                   rf[g] <= '0;
      else if (wb_we && wb_rd_addr == AW'(g))    rf[g] <= wb_data;
    end
  end

  always_comb begin
    rs1_val = rf[rs1];
    rs2_val = rf[rs2];
    if (BYPASS_WB && wb_we && wb_rd_addr != '0) begin
      if (wb_rd_addr == rs1) rs1_val = wb_data;
      if (wb_rd_addr == rs2) rs2_val = wb_data;
    end
  end

  // Immediates built at 32 bits then sign-extended (or truncated) to XLEN
  logic signed [31:0] imm_i32, imm_s32, imm_b32, imm_j32, imm_u32;
  logic [XLEN-1:0]    imm_i, imm_s, imm_b, imm_j, imm_u, imm_sel_val;

  assign imm_i32 = {{20{id_instr[31]}}, id_instr[31:20]};
  assign imm_s32 = {{20{id_instr[31]}}, id_instr[31:25], id_instr[11:7]};
  assign imm_b32 = {{19{id_instr[31]}}, id_instr[31], id_instr[7],
                    id_instr[30:25], id_instr[11:8], 1'b0};
  assign imm_j32 = {{11{id_instr[31]}}, id_instr[31], id_instr[19:12],
                    id_instr[20], id_instr[30:21], 1'b0};
  assign imm_u32 = {id_instr[31:12], 12'b0};

  assign imm_i = XLEN'(imm_i32);
  assign imm_s = XLEN'(imm_s32);
  assign imm_b = XLEN'(imm_b32);
  assign imm_j = XLEN'(imm_j32);
  assign imm_u = XLEN'(imm_u32);

  always_comb begin
    unique case (imm_sel)
      3'd1:    imm_sel_val = imm_s;
      3'd2:    imm_sel_val = imm_b;
      3'd3:    imm_sel_val = imm_j;
      3'd4:    imm_sel_val = imm_u;
      default: imm_sel_val = imm_i;
    endcase
  end

  assign br_target   = id_pc + imm_b;
  assign jal_target  = id_pc + imm_j;
  assign jalr_target = (rs1_val + imm_i) & ~XLEN'(1);

  idex_t ex_q;
  logic  hazard, advance;

  // Conservative: any rs field match counts, regardless of instruction format
  assign hazard = id_valid && ex_valid && ex_q.instr[6:0] == OP_LOAD &&
                  ex_q.rd_addr != '0 &&
                  (ex_q.rd_addr == rs1 || ex_q.rd_addr == rs2);
  assign hazard_stall = hazard && !flush;
  assign advance      = ex_ready || !ex_valid;
  assign id_ready     = flush || (advance && !hazard);

  logic cond;
  always_comb begin
    unique case (funct3)
      3'b000:  cond = (rs1_val == rs2_val);
      3'b001:  cond = (rs1_val != rs2_val);
      3'b100:  cond = ($signed(rs1_val) <  $signed(rs2_val));
      3'b101:  cond = ($signed(rs1_val) >= $signed(rs2_val));
      3'b110:  cond = (rs1_val <  rs2_val);
      3'b111:  cond = (rs1_val >= rs2_val);
      default: cond = 1'b0;
    endcase
  end

  assign br_taken = id_valid && !hazard && !flush && opcode == OP_BRANCH && cond;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid       <= 1'b0;
      ex_q           <= '0;
      ex_q.pc        <= RESET_PC;
      ex_q.instr     <= NOP_INSTR;
    end else if (flush) begin
      ex_valid       <= 1'b0;
      ex_q.instr     <= NOP_INSTR;
    end else if (advance && id_valid && !hazard) begin
      ex_valid       <= 1'b1;
      ex_q.pc        <= id_pc;
      ex_q.instr     <= id_instr;
      ex_q.rs1_data  <= rs1_val;
      ex_q.rs2_data  <= rs2_val;
      ex_q.imm       <= imm_sel_val;
      ex_q.rs1_addr  <= rs1;
      ex_q.rs2_addr  <= rs2;
      ex_q.rd_addr   <= rd;
    end else if (advance) begin
      ex_valid       <= 1'b0;
      ex_q.instr     <= NOP_INSTR;
    end
  end

  assign ex_pc       = ex_q.pc;
  assign ex_instr    = ex_q.instr;
  assign ex_rs1_data = ex_q.rs1_data;
  assign ex_rs2_data = ex_q.rs2_data;
  assign ex_imm      = ex_q.imm;
  assign ex_rs1_addr = ex_q.rs1_addr;
  assign ex_rs2_addr = ex_q.rs2_addr;
  assign ex_rd_addr  = ex_q.rd_addr;

endmodule

// File: tb/tb_id_stage_pipe.sv
// Directed bench for id_stage_pipe: reset, pass-through, bypass, load-use,
// backpressure/flush, branch resolution and target wrap.
module tb_id_stage_pipe;
  localparam int XLEN = 32;
  localparam int AW   = 5;

  logic            clk = 1'b0;
  logic            rst;
  logic            id_valid, id_ready;
  logic [XLEN-1:0] id_pc;
  logic [31:0]     id_instr;
  logic [2:0]      imm_sel;
  logic            flush;
  logic            wb_we;
  logic [AW-1:0]   wb_rd_addr;
  logic [XLEN-1:0] wb_data;
  logic            ex_valid, ex_ready;
  logic [XLEN-1:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
  logic [31:0]     ex_instr;
  logic [AW-1:0]   ex_rs1_addr, ex_rs2_addr, ex_rd_addr;
  logic            br_taken;
  logic [XLEN-1:0] br_target, jal_target, jalr_target;
  logic            hazard_stall;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  id_stage_pipe dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_ready(id_ready), .id_pc(id_pc), .id_instr(id_instr),
    .imm_sel(imm_sel), .flush(flush),
    .wb_we(wb_we), .wb_rd_addr(wb_rd_addr), .wb_data(wb_data),
    .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_pc(ex_pc), .ex_instr(ex_instr), .ex_rs1_data(ex_rs1_data),
    .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm),
    .ex_rs1_addr(ex_rs1_addr), .ex_rs2_addr(ex_rs2_addr), .ex_rd_addr(ex_rd_addr),
    .br_taken(br_taken), .br_target(br_target), .jal_target(jal_target),
    .jalr_target(jalr_target), .hazard_stall(hazard_stall)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] ins);
    id_valid = v;
    id_pc    = pc;
    id_instr = ins;
    #1;
  endtask

  task automatic wb(input logic we, input logic [4:0] a, input logic [31:0] d);
    wb_we      = we;
    wb_rd_addr = a;
    wb_data    = d;
  endtask

  initial begin
    rst = 1'b1; id_valid = 0; id_pc = '0; id_instr = 32'h13; imm_sel = 3'd0;
    flush = 0; ex_ready = 1; wb(0, 0, 0);
    #1;
    chk("rst_valid", ex_valid, 0);
    chk("rst_pc",    ex_pc,    0);
    chk("rst_instr", ex_instr, 32'h13);
    #12;
    rst = 1'b0;
    step();

    // x1 = -1, x2 = 1 via WB while ID is idle
    wb(1, 1, 32'hFFFF_FFFF); step();
    wb(1, 2, 32'h0000_0001); step();
    wb(0, 0, 0);

    // addi x1,x0,5 at 0x100
    drive(1, 32'h100, 32'h0050_0093);
    chk("pt_ready", id_ready, 1);
    step();
    chk("pt_valid", ex_valid,   1);
    chk("pt_pc",    ex_pc,      32'h100);
    chk("pt_imm",   ex_imm,     5);
    chk("pt_rd",    ex_rd_addr, 1);

    // add x4,x3,x0 with concurrent WB of x3
    wb(1, 3, 32'hDEAD);
    drive(1, 32'h104, 32'h0001_8233);
    step();
    chk("byp_rs1", ex_rs1_data, 32'hDEAD);
    wb(0, 0, 0);
    drive(1, 32'h104, 32'h0001_8233);
    step();
    chk("rf_rs1", ex_rs1_data, 32'hDEAD);

    // write to x0 must not stick or bypass
    wb(1, 0, 32'h1234);
    drive(1, 32'h104, 32'h0000_0233);
    step();
    chk("x0_byp", ex_rs1_data, 0);
    wb(0, 0, 0);
    step();
    chk("x0_rf", ex_rs1_data, 0);

    // lw x5,0(x1) then add x6,x5,x1
    drive(1, 32'h108, 32'h0000_A283);
    step();
    chk("lw_valid", ex_valid, 1);
    drive(1, 32'h10C, 32'h0012_8333);
    chk("lu_stall", hazard_stall, 1);
    chk("lu_ready", id_ready, 0);
    step();
    chk("lu_bub_valid", ex_valid, 0);
    chk("lu_bub_instr", ex_instr, 32'h13);
    chk("lu_nostall",   hazard_stall, 0);
    chk("lu_ready2",    id_ready, 1);
    step();
    chk("lu_iss_valid", ex_valid, 1);
    chk("lu_iss_instr", ex_instr, 32'h0012_8333);
    chk("lu_iss_rs2",   ex_rs2_data, 32'hFFFF_FFFF);

    // backpressure: EX holds the add for 3 cycles
    ex_ready = 0;
    drive(1, 32'h200, 32'h0090_0393);
    for (int i = 0; i < 3; i++) begin
      chk("bp_ready", id_ready, 0);
      step();
      chk("bp_pc",    ex_pc, 32'h10C);
      chk("bp_instr", ex_instr, 32'h0012_8333);
      chk("bp_valid", ex_valid, 1);
    end
    flush = 1; #1;
    chk("fl_ready", id_ready, 1);
    step();
    chk("fl_valid", ex_valid, 0);
    flush = 0; ex_ready = 1;

    // flush during a load-use stall
    drive(1, 32'h300, 32'h0000_A283);
    step();
    flush = 1;
    drive(1, 32'h304, 32'h0012_8333);
    chk("fls_stall", hazard_stall, 0);
    chk("fls_ready", id_ready, 1);
    step();
    chk("fls_valid", ex_valid, 0);
    flush = 0;

    // branches with x1=-1, x2=1
    drive(1, 32'h400, 32'h0020_C063);
    chk("blt",  br_taken, 1);
    drive(1, 32'h400, 32'h0020_E063);
    chk("bltu", br_taken, 0);
    drive(1, 32'hFFFF_FFFC, 32'h0000_0463);
    chk("beq_taken",  br_taken, 1);
    chk("beq_target", br_target, 32'h4);
    drive(1, 32'h100, 32'hFFDF_F06F);
    chk("jal_target", jal_target, 32'hFC);
    drive(1, 32'h100, 32'h0040_8067);
    chk("jalr_target", jalr_target, 32'h2);
    drive(0, 32'h100, 32'h0040_8067);
    chk("br_novalid", br_taken, 0);

    // U immediate through the pipe
    imm_sel = 3'd4;
    drive(1, 32'h500, 32'hABCD_E0B7);
    step();
    chk("u_imm", ex_imm, 32'hABCD_E000);
    imm_sel = 3'd0;

    // async reset mid-stream while EX is stalled
    drive(1, 32'h600, 32'h0050_0093);
    ex_ready = 0;
    step();
    chk("pre_rst_valid", ex_valid, 1);
    #3; rst = 1; #1;
    chk("mrst_valid", ex_valid, 0);
    chk("mrst_pc",    ex_pc,    0);
    chk("mrst_instr", ex_instr, 32'h13);
    drive(1, 32'h100, 32'h0040_8067);
    chk("mrst_rf", jalr_target, 32'h4);
    step();
    rst = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
